// File: rtl/scope_trigger_capture.sv
// Single-shot oscilloscope capture: circular record buffer with level/slope trigger and oldest-first readout.
// Optional build macro SCOPE_CAPTURE_DECIM_EN adds a decim input that keeps every (decim+1)-th valid sample.
module scope_trigger_capture #(
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 256,
  parameter int                PRE_TRIG = 64,
  parameter logic [DATA_W-1:0] HYST     = DATA_W'(32'h0000_1000)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              arm,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_slope,
  input  logic              force_trig,
`ifdef SCOPE_CAPTURE_DECIM_EN
  input  logic [7:0]        decim,
`endif
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (PRE_TRIG < 0 || PRE_TRIG >= DEPTH) begin : g_bad_pre_trig
    $error("scope_trigger_capture: PRE_TRIG must satisfy 0 <= PRE_TRIG < DEPTH");
  end
  if (DEPTH < 4 || (1 << AW) != DEPTH) begin : g_bad_depth
    $error("scope_trigger_capture: DEPTH must be a power of 2 and at least 4");
  end

  localparam logic [CW-1:0] PRE_LAST  = CW'(PRE_TRIG == 0 ? 0 : PRE_TRIG - 1);
  localparam logic [CW-1:0] POST_LAST = CW'(DEPTH - PRE_TRIG - 1);
  localparam logic [CW-1:0] RD_LAST   = CW'(DEPTH - 1);
  localparam logic [AW-1:0] PRE_OFS   = AW'(PRE_TRIG);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PRE   = 3'd1;
  localparam logic [2:0] S_ARMED = 3'd2;
  localparam logic [2:0] S_POST  = 3'd3;
  localparam logic [2:0] S_READ  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     trig_ptr_q, trig_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     rd_cnt_q, rd_cnt_d;
  logic              qual_q, qual_d;
  logic              s1_valid_q, s1_last_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_valid_q, out_last_q, done_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic use_sample, capturing, we;

`ifdef SCOPE_CAPTURE_DECIM_EN
  logic [7:0] phase_q, phase_d;

  assign use_sample = sample_valid && (phase_q == 8'd0);

  always_comb begin
    phase_d = phase_q;
    if (state_q == S_IDLE && arm)       phase_d = 8'd0;
    else if (capturing && sample_valid) phase_d = (phase_q == decim) ? 8'd0 : phase_q + 8'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) phase_q <= 8'd0;
    else        phase_q <= phase_d;
  end
`else
  assign use_sample = sample_valid;
`endif

  assign capturing = (state_q == S_PRE) || (state_q == S_ARMED) || (state_q == S_POST);
  assign we        = capturing && use_sample;

  // One extra bit of headroom so level +/- HYST cannot wrap.
  logic signed [DATA_W:0] s_x, lvl_x, lvl_lo, lvl_hi;
  logic                   qual_cond, fire_cond, trig_hit;

  assign s_x    = $signed({sample_in[DATA_W-1], sample_in});
  assign lvl_x  = $signed({trig_level[DATA_W-1], trig_level});
  assign lvl_lo = lvl_x - $signed({1'b0, HYST});
  assign lvl_hi = lvl_x + $signed({1'b0, HYST});

  assign qual_cond = trig_slope ? (s_x > lvl_hi)  : (s_x < lvl_lo);
  assign fire_cond = trig_slope ? (s_x <= lvl_x)  : (s_x >= lvl_x);
  assign trig_hit  = we && (state_q == S_ARMED) && (force_trig || (qual_q && fire_cond));

  // Readout pipeline: read stage (s1) feeds the output register; each advances when the next is free.
  logic out_adv, s1_adv, issue, xfer_last;

  assign out_adv   = !out_valid_q || out_ready;
  assign s1_adv    = !s1_valid_q || out_adv;
  assign issue     = (state_q == S_READ) && s1_adv && !rd_cnt_q[AW];
  assign xfer_last = out_valid_q && out_ready && out_last_q;

  // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = we ? wr_ptr_q + AW'(1) : wr_ptr_q;
    trig_ptr_d = trig_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    rd_cnt_d   = rd_cnt_q;
    qual_d     = qual_q;
    case (state_q)
      S_IDLE: if (arm) begin
        cnt_d   = '0;
        qual_d  = 1'b0;
        state_d = (PRE_TRIG == 0) ? S_ARMED : S_PRE;
      end
      S_PRE: if (we) begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == PRE_LAST) begin
          state_d = S_ARMED;
          qual_d  = 1'b0;
        end
      end
      S_ARMED: if (trig_hit) begin
        trig_ptr_d = wr_ptr_q;
        cnt_d      = CW'(1);
        if (POST_LAST == '0) begin
          state_d  = S_READ;
          rd_ptr_d = wr_ptr_q - PRE_OFS;
          rd_cnt_d = '0;
        end else begin
          state_d = S_POST;
        end
      end else if (we && qual_cond) begin
        qual_d = 1'b1;
      end
      S_POST: if (we) begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == POST_LAST) begin
          state_d  = S_READ;
          rd_ptr_d = trig_ptr_q - PRE_OFS;
          rd_cnt_d = '0;
        end
      end
      S_READ: begin
        if (issue) begin
          rd_ptr_d = rd_ptr_q + AW'(1);
          rd_cnt_d = rd_cnt_q + CW'(1);
        end
        if (xfer_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      trig_ptr_q  <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      rd_cnt_q    <= '0;
      qual_q      <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      trig_ptr_q <= trig_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      qual_q     <= qual_d;
      done_q     <= xfer_last;
      if (s1_adv) begin
        s1_valid_q <= issue;
        s1_last_q  <= issue && (rd_cnt_q == RD_LAST);
      end
      if (out_adv) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          out_data_q <= rd_data_q;
          out_last_q <= s1_last_q;
        end else begin
          out_last_q <= 1'b0;
        end
      end
    end
  end

  // NOTE: the sample store and its read register carry no reset so they map onto block RAM.
  always_ff @(posedge clock) begin
    if (we)    mem[wr_ptr_q] <= sample_in;
    if (issue) rd_data_q     <= mem[rd_ptr_q];
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_scope_trigger_capture.sv
// Directed bench for scope_trigger_capture: ramp, hysteresis, forced trigger, backpressure, reset abort, stray arm.
module tb_scope_trigger_capture;

  logic        clock;
  logic        reset;
  logic        arm;
  logic [31:0] sample_in;
  logic        sample_valid;
  logic [31:0] trig_level;
  logic        trig_slope;
  logic        force_trig;
  logic        busy;
  logic        done;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  scope_trigger_capture dut (
    .clock        (clock),
    .reset        (reset),
    .arm          (arm),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .trig_level   (trig_level),
    .trig_slope   (trig_slope),
    .force_trig   (force_trig),
    .busy         (busy),
    .done         (done),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  localparam int K_RAMP   = 0;
  localparam int K_TOGGLE = 1;
  localparam int K_ZERO   = 2;

  // k counts valid samples presented since arm.
  function automatic logic [31:0] gen(input int kind, input int k);
    logic [31:0] v;
    v = 32'h0;
    if (kind == K_RAMP) v = 32'(k) << 16;
    else if (kind == K_TOGGLE) begin
      if (k < 150)      v = (k % 2 == 0) ? 32'h0000_0800 : 32'hFFFF_F800;
      else if (k < 160) v = 32'h0002_0000;
      else              v = 32'hFFFE_0000;
    end
    return v;
  endfunction

  logic [31:0] rec[$];
  int          last_cnt;
  int          last_idx;
  int          done_cnt;
  bit          finished;

  task automatic capture(input logic slope, input logic [31:0] level, input int kind,
                         input bit rnd_ready, input bit gaps, input int force_k,
                         input bit arm_glitch, input int stop_k);
    int          k;
    int          cyc;
    bit          stall_prev;
    bit          vld;
    logic [31:0] prev_data;
    logic        prev_last;
    k = 0; cyc = 0; stall_prev = 0; prev_data = '0; prev_last = 1'b0;
    rec.delete(); last_cnt = 0; last_idx = -1; done_cnt = 0; finished = 0;
    @(negedge clock);
    trig_level = level; trig_slope = slope; force_trig = 1'b0;
    sample_valid = 1'b0; out_ready = 1'b1; arm = 1'b1;
    @(negedge clock);
    arm = 1'b0;
    while (!finished && cyc < 6000) begin
      if (stall_prev) begin
        check("stall_valid", 32'(out_valid), 32'h1);
        check("stall_data", out_data, prev_data);
        check("stall_last", 32'(out_last), 32'(prev_last));
      end
      if (done) begin
        done_cnt++;
        finished = 1;
        check("done_busy", 32'(busy), 32'h0);
        check("done_valid", 32'(out_valid), 32'h0);
      end else begin
        if (k == stop_k) begin
          sample_valid = 1'b0; force_trig = 1'b0; arm = 1'b0;
          return;
        end
        vld          = gaps ? ($urandom_range(3) != 0) : 1'b1;
        out_ready    = rnd_ready ? 1'($urandom_range(1)) : 1'b1;
        sample_valid = vld;
        sample_in    = gen(kind, k);
        force_trig   = vld && (k == force_k);
        arm          = arm_glitch && ((vld && k == 10) || rec.size() == 5);
        if (vld) k++;
        if (out_valid && out_ready) begin
          rec.push_back(out_data);
          if (out_last) begin
            last_cnt++;
            last_idx = rec.size() - 1;
          end
        end
        stall_prev = out_valid && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
        @(negedge clock);
        cyc++;
      end
    end
    sample_valid = 1'b0; force_trig = 1'b0; arm = 1'b0; out_ready = 1'b1;
    check("finished_in_budget", 32'(finished), 32'h1);
  endtask

  task automatic verify(input string name, input int kind, input int trig_k);
    int extra_done;
    int extra_busy;
    int extra_valid;
    extra_done = 0; extra_busy = 0; extra_valid = 0;
    check({name, "_len"}, 32'(rec.size()), 32'd256);
    for (int i = 0; i < 256 && i < rec.size(); i++)
      check($sformatf("%s_rec[%0d]", name, i), rec[i], gen(kind, trig_k - 64 + i));
    check({name, "_last_idx"}, 32'(last_idx), 32'd255);
    check({name, "_last_cnt"}, 32'(last_cnt), 32'd1);
    check({name, "_done_cnt"}, 32'(done_cnt), 32'd1);
    repeat (20) begin
      @(negedge clock);
      if (done)      extra_done++;
      if (busy)      extra_busy++;
      if (out_valid) extra_valid++;
    end
    check({name, "_extra_done"}, 32'(extra_done), 32'd0);
    check({name, "_idle_busy"}, 32'(extra_busy), 32'd0);
    check({name, "_idle_valid"}, 32'(extra_valid), 32'd0);
  endtask

  initial begin
    int rst_done;
    reset = 1'b0; arm = 1'b0; sample_in = '0; sample_valid = 1'b0;
    trig_level = '0; trig_slope = 1'b0; force_trig = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_last", 32'(out_last), 32'h0);
    check("rst_data", out_data, 32'h0);
    reset = 1'b1;
    @(negedge clock);
    check("idle_busy", 32'(busy), 32'h0);

    // 1: rising ramp, trigger on sample 128 (value 0x0080_0000).
    capture(1'b0, 32'h0080_0000, K_RAMP, 0, 0, -1, 0, -1);
    check("t1_idx0", rec[0], 32'h0040_0000);
    check("t1_idx64", rec[64], 32'h0080_0000);
    check("t1_idx255", rec[255], 32'h013F_0000);
    verify("t1", K_RAMP, 128);

    // 2: falling around 0 with toggles inside hysteresis; trigger at first -2.0 (k=160).
    capture(1'b1, 32'h0000_0000, K_TOGGLE, 0, 0, -1, 0, -1);
    check("t2_idx63", rec[63], 32'h0002_0000);
    check("t2_idx64", rec[64], 32'hFFFE_0000);
    verify("t2", K_TOGGLE, 160);

    // 3: constant zero, level never crossed, forced trigger at k=100.
    capture(1'b0, 32'h0080_0000, K_ZERO, 0, 0, 100, 0, -1);
    verify("t3", K_ZERO, 100);

    // 4: ramp with random backpressure and input gaps.
    capture(1'b0, 32'h0080_0000, K_RAMP, 1, 1, -1, 0, -1);
    verify("t4", K_RAMP, 128);

    // 5: reset during POST (k=200), then a clean record.
    capture(1'b0, 32'h0080_0000, K_RAMP, 0, 0, -1, 0, 200);
    check("t5_busy_before", 32'(busy), 32'h1);
    reset = 1'b0;
    #1;
    check("t5_rst_busy", 32'(busy), 32'h0);
    check("t5_rst_done", 32'(done), 32'h0);
    check("t5_rst_valid", 32'(out_valid), 32'h0);
    check("t5_rst_last", 32'(out_last), 32'h0);
    check("t5_rst_data", out_data, 32'h0);
    rst_done = 0;
    repeat (3) begin
      @(negedge clock);
      if (done || busy || out_valid) rst_done++;
    end
    reset = 1'b1;
    repeat (3) begin
      @(negedge clock);
      if (done || busy || out_valid) rst_done++;
    end
    check("t5_quiet_after_abort", 32'(rst_done), 32'd0);
    capture(1'b0, 32'h0080_0000, K_RAMP, 0, 0, -1, 0, -1);
    verify("t5", K_RAMP, 128);

    // 6: stray arm pulses in PRETRIG and READOUT are ignored.
    capture(1'b0, 32'h0080_0000, K_RAMP, 0, 0, -1, 1, -1);
    verify("t6", K_RAMP, 128);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
